// File: rtl/lz77_pkg.sv
// Shared constants and FSM state type for the LZ77 decoder.
// Optional codeword checking is enabled by defining LZ77_DEC_CHECK_EN.
package lz77_pkg;

    localparam int unsigned SEARCH_DEPTH = 9;
    localparam logic [7:0]  END_CHAR     = 8'h24;
    localparam int unsigned OFFSET_W     = 4;
    localparam int unsigned LEN_W        = 3;

    typedef enum logic [1:0] {
        StIdle,
        StCopy,
        StLit,
        StDone
    } state_t;

endpackage

// File: rtl/lz77_history.sv
// Sliding history window: entry 0 is the most recent character; a shift drops the oldest.
module lz77_history #(
    parameter int unsigned DEPTH = 9,
    parameter int unsigned IDX_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic             i_shift,
    input  logic [7:0]       i_data,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic [7:0]       o_rd_data
);

    logic [7:0] r_mem [DEPTH];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_clear) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_shift) begin
            r_mem[0] <= i_data;
            for (int i = 1; i < DEPTH; i++) r_mem[i] <= r_mem[i-1];
        end
    end

    // Indices past the window read as zero rather than aliasing.
    always_comb begin
        o_rd_data = '0;
        if (32'(i_rd_idx) < DEPTH) o_rd_data = r_mem[i_rd_idx];
    end

endmodule

// File: rtl/lz77_decoder.sv
// LZ77 codeword decoder: (offset, length, literal) -> length copies then the literal.
// Define LZ77_DEC_CHECK_EN to flag illegal codewords on err and decode them as length 0.
module lz77_decoder #(
    parameter int unsigned SEARCH_DEPTH = lz77_pkg::SEARCH_DEPTH,
    parameter logic [7:0]  END_CHAR     = lz77_pkg::END_CHAR
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_offset,
    input  logic [2:0] in_match_len,
    input  logic [7:0] in_char,
    output logic       out_valid,
    output logic [7:0] out_char,
    output logic       done,
    output logic       err
);

    import lz77_pkg::*;

    localparam int unsigned FILL_W = $clog2(SEARCH_DEPTH + 1);

    state_t            r_state, w_state_next;
    logic [3:0]        r_offset;
    logic [2:0]        r_len;
    logic [7:0]        r_lit;
    logic [7:0]        r_out_char;
    logic [FILL_W-1:0] r_fill;

    logic       w_accept;
    logic       w_illegal;
    logic [2:0] w_len_eff;
    logic [7:0] w_hist_rd;
    logic [7:0] w_copy_char;
    logic [7:0] w_emit_char;
    logic       w_clear;

    assign w_accept  = in_valid && (r_state == StIdle);
    assign w_len_eff = w_illegal ? 3'd0 : in_match_len;

`ifdef LZ77_DEC_CHECK_EN
    logic r_err;

    always_comb begin
        w_illegal = 1'b0;
        if (32'(in_offset) >= SEARCH_DEPTH) w_illegal = 1'b1;
        if ((in_match_len != 3'd0) && (32'(in_offset) >= 32'(r_fill))) w_illegal = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_accept && w_illegal) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign w_illegal = 1'b0;
    assign err       = 1'b0;
`endif

    lz77_history #(
        .DEPTH (SEARCH_DEPTH),
        .IDX_W (4)
    ) u_history (
        .i_clk     (clk),
        .i_rst     (reset),
        .i_clear   (w_clear),
        .i_shift   (out_valid),
        .i_data    (w_emit_char),
        .i_rd_idx  (r_offset),
        .o_rd_data (w_hist_rd)
    );

    // Entries beyond the fill level are always zero, so gating on fill keeps reads exact.
    assign w_copy_char = (32'(r_offset) < 32'(r_fill)) ? w_hist_rd : 8'h00;

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        done         = 1'b0;
        w_clear      = 1'b0;
        w_emit_char  = r_lit;
        unique case (r_state)
            StIdle: begin
                in_ready = 1'b1;
                if (w_accept) w_state_next = (w_len_eff != 3'd0) ? StCopy : StLit;
            end
            StCopy: begin
                out_valid   = 1'b1;
                w_emit_char = w_copy_char;
                if (r_len == 3'd1) w_state_next = StLit;
            end
            StLit: begin
                out_valid    = 1'b1;
                w_state_next = (r_lit == END_CHAR) ? StDone : StIdle;
            end
            StDone: begin
                done         = 1'b1;
                w_clear      = 1'b1;
                w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    assign out_char = out_valid ? w_emit_char : r_out_char;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= StIdle;
            r_offset   <= '0;
            r_len      <= '0;
            r_lit      <= '0;
            r_out_char <= '0;
            r_fill     <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_offset <= in_offset;
                r_len    <= w_len_eff;
                r_lit    <= in_char;
            end else if (r_state == StCopy) begin
                r_len <= r_len - 1'b1;
            end
            if (out_valid) r_out_char <= w_emit_char;
            if (w_clear) begin
                r_fill <= '0;
            end else if (out_valid && (r_fill != FILL_W'(SEARCH_DEPTH))) begin
                r_fill <= r_fill + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lz77_decoder.sv
// Self-checking bench for lz77_decoder against a queue-based LZ77 reference model.
module tb_lz77_decoder;

    localparam int         DEPTH = 9;
    localparam logic [7:0] ENDC  = 8'h24;
`ifdef LZ77_DEC_CHECK_EN
    localparam bit CHECK = 1'b1;
`else
    localparam bit CHECK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_offset;
    logic [2:0] in_match_len;
    logic [7:0] in_char;
    logic       out_valid;
    logic [7:0] out_char;
    logic       done;
    logic       err;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] m_hist[$];
    logic [7:0] m_exp[$];
    bit         m_err;

    always #5 clk = ~clk;

    lz77_decoder dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_offset    (in_offset),
        .in_match_len (in_match_len),
        .in_char      (in_char),
        .out_valid    (out_valid),
        .out_char     (out_char),
        .done         (done),
        .err          (err)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic hist_push(input logic [7:0] c);
        m_hist.push_front(c);
        if (m_hist.size() > DEPTH) void'(m_hist.pop_back());
    endtask

    // Reference: expected output characters of one codeword, plus whether it ends the stream.
    task automatic model(input int off, input int len, input logic [7:0] ch, output bit exp_done);
        logic [7:0] c;
        bit illegal;
        illegal = CHECK && ((off >= DEPTH) || ((len > 0) && (off >= m_hist.size())));
        if (illegal) begin
            m_err = 1'b1;
            len = 0;
        end
        m_exp = {};
        for (int i = 0; i < len; i++) begin
            c = (off < m_hist.size()) ? m_hist[off] : 8'h00;
            m_exp.push_back(c);
            hist_push(c);
        end
        m_exp.push_back(ch);
        hist_push(ch);
        exp_done = (ch == ENDC);
        if (exp_done) m_hist = {};
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        reset    = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        m_hist = {};
        m_err  = 1'b0;
    endtask

    task automatic send(input int off, input int len, input logic [7:0] ch, input string tag);
        int n;
        bit exp_done;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL %s ready_timeout: in_ready=%b required 1", tag, in_ready);
            return;
        end
        in_offset    = 4'(off);
        in_match_len = 3'(len);
        in_char      = ch;
        in_valid     = 1'b1;
        model(off, len, ch, exp_done);
        foreach (m_exp[k]) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || out_char !== m_exp[k] || in_ready !== 1'b0) begin
                n_errors++;
                $display("FAIL %s out[%0d]: valid=%b char=%h ready=%b required valid=1 char=%h ready=0",
                         tag, k, out_valid, out_char, in_ready, m_exp[k]);
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || done !== exp_done || out_char !== m_exp[$]
            || in_ready !== !exp_done) begin
            n_errors++;
            $display("FAIL %s tail: valid=%b done=%b char=%h ready=%b required valid=0 done=%b char=%h ready=%b",
                     tag, out_valid, done, out_char, in_ready, exp_done, m_exp[$], !exp_done);
        end
        n_checks++;
        if (err !== m_err) begin
            n_errors++;
            $display("FAIL %s err: got %b required %b", tag, err, m_err);
        end
    endtask

    task automatic test_reset();
        in_valid = 1'b0;
        in_offset = '0;
        in_match_len = '0;
        in_char = '0;
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset in_ready: got %b required 1", in_ready); end
        n_checks++;
        if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset out_valid: got %b required 0", out_valid); end
        n_checks++;
        if (out_char !== 8'h00) begin n_errors++; $display("FAIL reset out_char: got %h required 00", out_char); end
        n_checks++;
        if (done !== 1'b0) begin n_errors++; $display("FAIL reset done: got %b required 0", done); end
        n_checks++;
        if (err !== 1'b0) begin n_errors++; $display("FAIL reset err: got %b required 0", err); end
        reset = 1'b0;
        m_hist = {};
        m_err  = 1'b0;
    endtask

    task automatic test_literal();
        do_reset();
        send(0, 0, 8'h41, "literal_A");
    endtask

    task automatic test_copy();
        do_reset();
        send(0, 0, 8'h41, "copy_A");
        send(0, 0, 8'h42, "copy_B");
        send(1, 2, 8'h43, "copy_ABC");
    endtask

    task automatic test_overlap();
        do_reset();
        send(0, 0, 8'h41, "overlap_A");
        send(0, 5, 8'h42, "overlap_AAAAAB");
    endtask

    task automatic test_end_char();
        do_reset();
        send(0, 0, 8'h51, "end_pre");
        send(0, 0, ENDC, "end_dollar");
        send(0, 2, 8'h5a, "end_hist_zero");
    endtask

    task automatic test_illegal();
        do_reset();
        send(3, 2, 8'h58, "illegal_empty");
        send(12, 0, 8'h59, "illegal_offset");
    endtask

    task automatic test_reset_mid();
        do_reset();
        send(0, 0, 8'h41, "mid_pre");
        in_offset = 4'd0;
        in_match_len = 3'd7;
        in_char = 8'h51;
        in_valid = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1) begin n_errors++; $display("FAIL mid_copy valid: got %b required 1", out_valid); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_char !== 8'h00) begin
            n_errors++;
            $display("FAIL mid_reset: valid=%b ready=%b char=%h required valid=0 ready=1 char=00",
                     out_valid, in_ready, out_char);
        end
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        m_hist = {};
        m_err  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL mid_after[%0d] out_valid: got %b required 0", i, out_valid);
            end
        end
    endtask

    task automatic test_random();
        int off;
        int len;
        logic [7:0] ch;
        do_reset();
        for (int i = 0; i < 80; i++) begin
            off = $urandom_range(0, 15);
            len = $urandom_range(0, 7);
            if ($urandom_range(0, 9) == 0) ch = ENDC;
            else ch = 8'(8'h41 + $urandom_range(0, 25));
            send(off, len, ch, $sformatf("rand%0d", i));
        end
    endtask

    initial begin
        test_reset();
        test_literal();
        test_copy();
        test_overlap();
        test_end_char();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lz77_decoder.md
LZ77_DECODER -- requirements
Module: lz77_decoder

Interface
REQ-001 SHALL have parameter SEARCH_DEPTH, default 9, number of history entries.
REQ-002 SHALL have parameter END_CHAR, default 8'h24, the end-of-stream literal.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  codeword present.
REQ-006 SHALL have port in_ready  output  1  decoder can accept a codeword.
REQ-007 SHALL have port in_offset  input  4  history index of match start; 0 is the most recent char.
REQ-008 SHALL have port in_match_len  input  3  number of copied chars, 0..7.
REQ-009 SHALL have port in_char  input  8  literal emitted after the copy.
REQ-010 SHALL have port out_valid  output  1  out_char valid this cycle.
REQ-011 SHALL have port out_char  output  8  decoded character.
REQ-012 SHALL have port done  output  1  one-cycle pulse after END_CHAR is emitted.
REQ-013 SHALL have port err  output  1  sticky illegal-codeword flag (see Configuration).

Function
REQ-014 SHALL implement states IDLE, COPY, LIT, DONE.
REQ-015 SHALL drive in_ready=1 only in IDLE; a codeword is accepted on in_valid&&in_ready.
REQ-016 On accept SHALL latch offset, length and literal, then go to COPY if length>0, else LIT.
REQ-017 In COPY, each cycle SHALL emit history[offset], shift it into history[0], and decrement the remaining length; at the last copy SHALL go to LIT.
REQ-018 The latched offset SHALL stay fixed while history shifts, so overlapping matches (offset<length) replicate correctly.
REQ-019 In LIT SHALL emit the latched literal and shift it into history[0].
REQ-020 From LIT: if literal==END_CHAR SHALL go to DONE, else to IDLE.
REQ-021 DONE SHALL assert done for one cycle, clear history to 0, then return to IDLE.
REQ-022 A codeword of length L SHALL give L+1 consecutive out_valid cycles, starting the cycle after accept; per-codeword period is L+2 cycles.
REQ-023 out_char SHALL hold its last value when out_valid=0.
REQ-024 in_valid in a non-IDLE state SHALL be ignored; the source holds it.
REQ-025 history SHALL be SEARCH_DEPTH x 8-bit; a shift discards history[SEARCH_DEPTH-1].
REQ-026 A history-fill counter SHALL saturate at SEARCH_DEPTH and clear in DONE.

Reset
REQ-027 Reset SHALL force IDLE, clear history and the fill counter, and drive in_ready=1, out_valid=0, out_char=0, done=0, err=0.
REQ-028 Reset mid-codeword SHALL abandon it with no further out_valid.

Configuration
REQ-029 With LZ77_DEC_CHECK_EN defined, a codeword SHALL be illegal if in_offset>=SEARCH_DEPTH, or if in_match_len>0 and in_offset>=fill count.
REQ-030 With LZ77_DEC_CHECK_EN defined, an illegal codeword SHALL set err (sticky until reset) and SHALL be decoded as if its length were 0.
REQ-031 Without LZ77_DEC_CHECK_EN, err SHALL be tied 0 and codewords SHALL be used unchecked; out-of-range offset reads give 0.

Structure
REQ-032 A shared package lz77_pkg SHALL hold SEARCH_DEPTH, END_CHAR, the offset/length widths, and the state enum.
REQ-033 History SHALL be a sub-module lz77_history (shift register, read port indexed by offset, clear input).

Verification
REQ-034 Reset, then (0,0,'A'): out 'A' one cycle after accept; in_ready low for 1 cycle.
REQ-035 After "AB", (1,2,'C'): out 'A','B','C' on 3 consecutive cycles.
REQ-036 After 'A', (0,5,'B'): out "AAAAAB" (overlap copy).
REQ-037 (0,0,8'h24): out '$', done pulses next cycle, then history reads 0.
REQ-038 With LZ77_DEC_CHECK_EN, on an empty history (3,2,'X'): err=1 and out 'X' only.
REQ-039 Assert reset during COPY of a length-7 codeword: out_valid drops immediately and in_ready=1.
